ioctl_stream_tx: RTL and testbench

//  Transmit end of the ioctl ROM-download interface. Takes a byte stream (valid/ready) and a transfer

---
 rtl/ioctl_stream_tx.sv | 189 ++++++++++++++++++
 tb/tb_ioctl_stream_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_stream_tx.sv
// ioctl ROM-download transmitter: byte stream plus descriptor in, ioctl write strobes out.
// Define IOCTL_TX_SUM_EN to add the 16-bit additive checksum output 'sum'.
module ioctl_stream_tx #(
   parameter int ADDR_W    = 25,
   parameter int WR_GAP    = 2,
   parameter int POST_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ioctl_download,
   output logic              ioctl_wr,
   output logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_dout,
   input  logic              ioctl_wait,
   output logic              busy,
   output logic              done,
   output logic              aborted
`ifdef IOCTL_TX_SUM_EN
   ,
   output logic [15:0]       sum
`endif
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SETUP = 3'd1;
   localparam logic [2:0] FETCH = 3'd2;
   localparam logic [2:0] ISSUE = 3'd3;
   localparam logic [2:0] GAP   = 3'd4;
   localparam logic [2:0] DRAIN = 3'd5;
   localparam logic [2:0] HOLD  = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, idx_q, idx_d, addr_q, addr_d;
   logic [7:0]        dout_q, dout_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              rdy_q, rdy_d, dl_q, dl_d, wr_q, wr_d;
   logic              busy_q, busy_d, done_q, done_d, abt_q, abt_d;
`ifdef IOCTL_TX_SUM_EN
   logic [15:0]       sum_q, sum_d;
`endif

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      rdy_d   = rdy_q;
      dl_d    = dl_q;
      busy_d  = busy_q;
      wr_d    = 1'b0;
      done_d  = 1'b0;
      abt_d   = 1'b0;
`ifdef IOCTL_TX_SUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start && !abort) begin
               base_d = base_addr;
               len_d  = length;
               idx_d  = '0;
               busy_d = 1'b1;
`ifdef IOCTL_TX_SUM_EN
               sum_d  = '0;
`endif
               // Zero-length transfer completes without opening a download window.
               if (length == '0) done_d = 1'b1;
               else begin
                  state_d = SETUP;
                  dl_d    = 1'b1;
               end
            end
         end
         SETUP: begin
            state_d = FETCH;
            rdy_d   = 1'b1;
         end
         FETCH: if (s_valid && rdy_q) begin
            dout_d  = s_data;
            addr_d  = base_q + idx_q;
            rdy_d   = 1'b0;
            state_d = ISSUE;
         end
         ISSUE: if (!ioctl_wait) begin
            wr_d    = 1'b1;
            idx_d   = idx_q + 1'b1;
            cnt_d   = '0;
            state_d = GAP;
`ifdef IOCTL_TX_SUM_EN
            sum_d   = sum_q + {8'h00, dout_q};
`endif
         end
         // The strobe cycle itself is GAP count 0, followed by WR_GAP idle cycles.
         GAP: if (cnt_q == 16'(WR_GAP)) begin
            if (idx_q == len_q) state_d = DRAIN;
            else begin
               state_d = FETCH;
               rdy_d   = 1'b1;
            end
         end else cnt_d = cnt_q + 16'd1;
         DRAIN: if (!ioctl_wait) begin
            state_d = HOLD;
            cnt_d   = '0;
         end
         HOLD: if (cnt_q == 16'(POST_HOLD - 1)) begin
            dl_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end else cnt_d = cnt_q + 16'd1;
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && abort) begin
         state_d = IDLE;
         wr_d    = 1'b0;
         dl_d    = 1'b0;
         rdy_d   = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         abt_d   = 1'b1;
         idx_d   = idx_q;
`ifdef IOCTL_TX_SUM_EN
         sum_d   = sum_q;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
         dl_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abt_q   <= 1'b0;
`ifdef IOCTL_TX_SUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         rdy_q   <= rdy_d;
         dl_q    <= dl_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abt_q   <= abt_d;
`ifdef IOCTL_TX_SUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign s_ready        = rdy_q;
   assign ioctl_download = dl_q;
   assign ioctl_wr       = wr_q;
   assign ioctl_addr     = addr_q;
   assign ioctl_dout     = dout_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign aborted        = abt_q;
`ifdef IOCTL_TX_SUM_EN
   assign sum            = sum_q;
`endif

endmodule

// File: tb/tb_ioctl_stream_tx.sv
// Scoreboard bench for ioctl_stream_tx: expected writes queued by stimulus, checked by a monitor.
module tb_ioctl_stream_tx;
   localparam int ADDR_W = 25, WR_GAP = 2, POST_HOLD = 4;

   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0, length = '0;
   logic [7:0] s_data = '0;
   logic s_valid = 1'b0, ioctl_wait = 1'b0;
   logic s_ready, ioctl_download, ioctl_wr, busy, done, aborted;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [7:0] ioctl_dout;
`ifdef IOCTL_TX_SUM_EN
   logic [15:0] sum;
`endif

   ioctl_stream_tx #(.ADDR_W(ADDR_W), .WR_GAP(WR_GAP), .POST_HOLD(POST_HOLD)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .base_addr(base_addr), .length(length), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
      .busy(busy), .done(done), .aborted(aborted)
`ifdef IOCTL_TX_SUM_EN
      , .sum(sum)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0, wr_cnt = 0, done_cnt = 0, abt_cnt = 0;
   int last_wr_cyc = -1000, done_cyc = 0, dl_fall_cyc = 0;
   logic wait_at_edge = 1'b0, dl_prev = 1'b0, dl_seen = 1'b0;
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [7:0] exp_data_q[$];
   logic [7:0] src_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
      src_q.push_back(d);
   endtask

   // posedge bookkeeping: cycle count and the ioctl_wait value the DUT samples
   initial forever begin
      @(posedge clk);
      cyc++;
      wait_at_edge = ioctl_wait;
   end

   // monitor / scoreboard
   initial forever begin
      @(negedge clk);
      if (ioctl_download) dl_seen = 1'b1;
      if (dl_prev && !ioctl_download) dl_fall_cyc = cyc;
      dl_prev = ioctl_download;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (aborted) abt_cnt++;
      if (ioctl_wr) begin
         wr_cnt++;
         checks++;
         if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: addr %0h data %0h, expected no write", ioctl_addr, ioctl_dout);
         end else begin
            chk("wr_addr", 32'(ioctl_addr), 32'(exp_addr_q.pop_front()));
            chk("wr_data", 32'(ioctl_dout), 32'(exp_data_q.pop_front()));
         end
         chk("wr_while_wait", 32'(wait_at_edge), 32'd0);
         if (cyc - last_wr_cyc < WR_GAP + 2) chk("wr_spacing", 32'(cyc - last_wr_cyc), 32'(WR_GAP + 2));
         last_wr_cyc = cyc;
      end
   end

   // source feeder: a byte leaves the queue once the DUT has accepted it
   initial forever begin
      logic acc;
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc && src_q.size() > 0) void'(src_q.pop_front());
      s_valid = (src_q.size() > 0);
      if (src_q.size() > 0) s_data = src_q[0];
   end

   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; length = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 1000) begin @(negedge clk); n++; end
      chk({name, "_done_timeout"}, 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic wait_wr(input int target, input string name);
      int n = 0;
      while (wr_cnt < target && n < 1000) begin @(negedge clk); n++; end
      chk({name, "_wr_timeout"}, 32'(wr_cnt >= target), 32'd1);
   endtask

   initial begin
      int w0, d0, f_cyc, a0;
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_download", 32'(ioctl_download), 0);
      chk("rst_wr", 32'(ioctl_wr), 0);
      chk("rst_addr", 32'(ioctl_addr), 0);
      chk("rst_busy_done", 32'({busy, done, aborted, s_ready}), 0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);

      // 1: basic 4-byte transfer
      push_wr(25'h0, 8'h11); push_wr(25'h1, 8'h22); push_wr(25'h2, 8'h33); push_wr(25'h3, 8'h44);
      w0 = wr_cnt; d0 = done_cnt;
      do_start(25'h0, 25'd4);
      @(negedge clk);
      chk("t1_busy", 32'(busy), 1);
      wait_done(d0 + 1, "t1");
      chk("t1_wr_count", 32'(wr_cnt - w0), 4);
      chk("t1_exp_empty", 32'(exp_addr_q.size()), 0);
      chk("t1_dl_low", 32'(ioctl_download), 0);
      chk("t1_dl_fall_at_done", 32'(dl_fall_cyc), 32'(done_cyc));
      chk("t1_hold_min", 32'(done_cyc - last_wr_cyc >= POST_HOLD + 1), 1);
      chk("t1_hold_max", 32'(done_cyc - last_wr_cyc <= POST_HOLD + WR_GAP + 3), 1);
      repeat (3) @(negedge clk);
      chk("t1_done_once", 32'(done_cnt - d0), 1);

      // 2: back-pressure after first write
      push_wr(25'h100, 8'hA1); push_wr(25'h101, 8'hB2); push_wr(25'h102, 8'hC3);
      w0 = wr_cnt; d0 = done_cnt;
      do_start(25'h100, 25'd3);
      wait_wr(w0 + 1, "t2");
      @(posedge clk); #1 ioctl_wait = 1'b1;
      repeat (10) @(posedge clk);
      #1 ioctl_wait = 1'b0;
      f_cyc = cyc;
      chk("t2_no_wr_in_wait", 32'(wr_cnt - w0), 1);
      wait_wr(w0 + 2, "t2b");
      chk("t2_wr_after_wait", 32'(last_wr_cyc), 32'(f_cyc + 1));
      wait_done(d0 + 1, "t2");
      chk("t2_wr_count", 32'(wr_cnt - w0), 3);

      // 3: zero length
      w0 = wr_cnt; d0 = done_cnt;
      repeat (2) @(negedge clk);
      dl_seen = 1'b0;
      do_start(25'h55, 25'd0);
      @(negedge clk);
      chk("t3_done", 32'(done), 1);
      chk("t3_busy", 32'(busy), 1);
      @(negedge clk);
      chk("t3_done_fall", 32'(done), 0);
      chk("t3_busy_fall", 32'(busy), 0);
      repeat (5) @(negedge clk);
      chk("t3_no_download", 32'(dl_seen), 0);
      chk("t3_no_wr", 32'(wr_cnt - w0), 0);

      // 4: address wrap
      push_wr(25'h1FFFFFE, 8'h5A); push_wr(25'h1FFFFFF, 8'h6B); push_wr(25'h0000000, 8'h7C);
      w0 = wr_cnt; d0 = done_cnt;
      do_start(25'h1FFFFFE, 25'd3);
      wait_done(d0 + 1, "t4");
      chk("t4_wr_count", 32'(wr_cnt - w0), 3);

      // 5: abort after 3rd write, then a normal transfer
      for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h80 + i));
      for (int i = 0; i < 3; i++) begin
         exp_addr_q.push_back(25'(25'h40 + i));
         exp_data_q.push_back(8'(8'h80 + i));
      end
      w0 = wr_cnt; d0 = done_cnt; a0 = abt_cnt;
      do_start(25'h40, 25'd8);
      wait_wr(w0 + 3, "t5");
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("t5_dl_low", 32'(ioctl_download), 0);
      chk("t5_aborted", 32'(aborted), 1);
      chk("t5_rdy_wr", 32'({s_ready, ioctl_wr}), 0);
      chk("t5_busy", 32'(busy), 0);
      repeat (10) @(negedge clk);
      chk("t5_wr_count", 32'(wr_cnt - w0), 3);
      chk("t5_no_done", 32'(done_cnt - d0), 0);
      chk("t5_abort_once", 32'(abt_cnt - a0), 1);
      chk("t5_bytes_left", 32'(src_q.size()), 5);
      src_q.delete();
      push_wr(25'h60, 8'hDE); push_wr(25'h61, 8'hAD);
      w0 = wr_cnt; d0 = done_cnt;
      do_start(25'h60, 25'd2);
      wait_done(d0 + 1, "t5b");
      chk("t5b_wr_count", 32'(wr_cnt - w0), 2);

      // 6: checksum and start during busy ignored
      push_wr(25'h300, 8'hFF); push_wr(25'h301, 8'hFF); push_wr(25'h302, 8'h02);
      w0 = wr_cnt; d0 = done_cnt;
      do_start(25'h300, 25'd3);
      wait_wr(w0 + 1, "t6");
      do_start(25'h999, 25'd5);
      wait_done(d0 + 1, "t6");
      repeat (3) @(negedge clk);
      chk("t6_wr_count", 32'(wr_cnt - w0), 3);
      chk("t6_exp_empty", 32'(exp_addr_q.size()), 0);
      chk("t6_done_once", 32'(done_cnt - d0), 1);
`ifdef IOCTL_TX_SUM_EN
      chk("t6_sum", 32'(sum), 32'h0200);
`endif

      // async reset mid-transfer
      push_wr(25'h500, 8'h01); push_wr(25'h501, 8'h02); push_wr(25'h502, 8'h03);
      w0 = wr_cnt;
      do_start(25'h500, 25'd3);
      wait_wr(w0 + 1, "t7");
      #2 reset_n = 1'b0;
      #1;
      chk("t7_rst_dl", 32'(ioctl_download), 0);
      chk("t7_rst_busy", 32'(busy), 0);
      exp_addr_q.delete(); exp_data_q.delete(); src_q.delete();
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
